// File: rtl/core_dmem_responder.sv
// core_dmem_responder: responder end of the core data memory bus, backed by a 64-bit word SRAM.
// Define DMEM_RESPONDER_STALL_EN to add 0..3 LFSR-driven stall cycles per request.
module core_dmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h0001_0000,
  parameter int          LATENCY    = 1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        dmem_req,
  input  logic [63:0] dmem_addr,
  input  logic        dmem_wen,
  input  logic [7:0]  dmem_strb,
  input  logic [63:0] dmem_wdata,
  output logic        dmem_gnt,
  output logic        dmem_err,
  output logic [63:0] dmem_rdata,
  output logic [1:0]  dbg_state
);
  localparam int CNT_W = 5;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt, load_cnt, stall;
  logic [63:0]           addr_q, wdata_q;
  logic                  wen_q;
  logic [7:0]            strb_q;
  logic [63:0]           cur_addr, cur_wdata, offset;
  logic                  cur_wen;
  logic [7:0]            cur_strb;
  logic                  in_range, accept, enter_resp;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_offset_lsbs;
  logic [63:0]           mem [DEPTH];

`ifdef DMEM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge g_clk) begin
    if (g_reset) lfsr <= 16'hACE1;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = CNT_W'(lfsr[1:0]);
`else
  assign stall = '0;
`endif

  assign load_cnt  = CNT_W'(LATENCY - 1) + stall;
  assign dbg_state = state;

  // Handshake: req is accepted only in IDLE and must then be held until gnt; gnt is a
  // single-cycle completion pulse, and a req still high in the cycle after gnt is a new request.
  // In IDLE the live bus is used so a zero-wait access can complete on its acceptance edge.
  assign cur_addr  = (state == IDLE) ? dmem_addr  : addr_q;
  assign cur_wen   = (state == IDLE) ? dmem_wen   : wen_q;
  assign cur_strb  = (state == IDLE) ? dmem_strb  : strb_q;
  assign cur_wdata = (state == IDLE) ? dmem_wdata : wdata_q;

  assign offset             = cur_addr - BASE_ADDR;
  assign in_range           = (cur_addr >= BASE_ADDR) && (offset[63:DEPTH_LOG2+3] == '0);
  assign idx                = offset[DEPTH_LOG2+2:3];
  assign unused_offset_lsbs = ^offset[2:0];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (dmem_req) begin
          accept  = 1'b1;
          cnt_nxt = load_cnt;
          if (load_cnt == '0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_gnt   <= 1'b0;
      dmem_err   <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dmem_gnt   <= enter_resp;
      dmem_err   <= enter_resp && !in_range;
      dmem_rdata <= (enter_resp && in_range && !cur_wen) ? mem[idx] : '0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (accept) begin
      addr_q  <= dmem_addr;
      wen_q   <= dmem_wen;
      strb_q  <= dmem_strb;
      wdata_q <= dmem_wdata;
    end
  end

  // A reset on the would-be commit edge wins, so an interrupted write never lands.
  always_ff @(posedge g_clk) begin
    if (!g_reset && enter_resp && in_range && cur_wen) begin
      for (int i = 0; i < 8; i++) begin
        if (cur_strb[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_core_dmem_responder.sv
// Bench for core_dmem_responder: two instances (LATENCY 1 and 4) on a shared clock/reset,
// checked every cycle against a word-array model and an expected-response queue per instance.
module tb_core_dmem_responder;
  localparam int          DL   = 4;
  localparam int          NW   = 1 << DL;
  localparam logic [63:0] BASE = 64'h0001_0000;
  localparam logic [63:0] SIZE = 64'(1) << (DL + 3);
`ifdef DMEM_RESPONDER_STALL_EN
  localparam int MAX_STALL = 3;
`else
  localparam int MAX_STALL = 0;
`endif

  typedef struct packed {
    logic [31:0] acc;
    logic        err;
    logic [63:0] data;
  } exp_t;

  logic            g_clk   = 1'b0;
  logic            g_reset = 1'b1;
  logic [1:0]      req     = '0;
  logic [1:0]      wen     = '0;
  logic [1:0][63:0] addr   = '0;
  logic [1:0][63:0] wdata  = '0;
  logic [1:0][7:0] strb    = '0;
  logic [1:0]      gnt, err;
  logic [1:0][63:0] rdata;
  logic [1:0][1:0] dbg;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic [63:0] mdl [2][NW];

  // clock / reset block
  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  core_dmem_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(1)) u_dut0 (
    .g_clk(g_clk), .g_reset(g_reset), .dmem_req(req[0]), .dmem_addr(addr[0]),
    .dmem_wen(wen[0]), .dmem_strb(strb[0]), .dmem_wdata(wdata[0]), .dmem_gnt(gnt[0]),
    .dmem_err(err[0]), .dmem_rdata(rdata[0]), .dbg_state(dbg[0])
  );

  core_dmem_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(4)) u_dut1 (
    .g_clk(g_clk), .g_reset(g_reset), .dmem_req(req[1]), .dmem_addr(addr[1]),
    .dmem_wen(wen[1]), .dmem_strb(strb[1]), .dmem_wdata(wdata[1]), .dmem_gnt(gnt[1]),
    .dmem_err(err[1]), .dmem_rdata(rdata[1]), .dbg_state(dbg[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
    end
  endtask

  // scoreboard model: plain byte-address arithmetic over a word array
  task automatic model_txn(input int d, input logic [63:0] a, input logic w, input logic [7:0] s,
                           input logic [63:0] wd, output exp_t e);
    int idx;
    e.acc  = 32'(cyc + 1);
    e.err  = 1'b0;
    e.data = '0;
    if (a < BASE || a >= BASE + SIZE) begin
      e.err = 1'b1;
    end else begin
      idx = int'((a - BASE) / 8);
      if (!w) e.data = mdl[d][idx];
      else for (int i = 0; i < 8; i++) if (s[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  // compare process
  task automatic cmp_port(input int d);
    exp_t e;
    bit   have;
    int   lat;
    have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
    e    = '0;
    if (have) e = (d == 0) ? exp_q0[0] : exp_q1[0];
    lat = cyc - int'(e.acc) + 1;
    if (gnt[d]) begin
      if (!have) begin
        chk($sformatf("dut%0d_spurious_gnt", d), 64'(gnt[d]), 64'd0);
      end else begin
        if (d == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
        chk_range($sformatf("dut%0d_gnt_latency", d), lat, lat_of(d), lat_of(d) + MAX_STALL);
        chk($sformatf("dut%0d_err", d), 64'(err[d]), 64'(e.err));
        chk($sformatf("dut%0d_rdata", d), rdata[d], e.data);
      end
    end else if (have && lat > lat_of(d) + MAX_STALL) begin
      chk($sformatf("dut%0d_gnt_timeout", d), 64'(gnt[d]), 64'd1);
      if (d == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
  endtask

  always @(negedge g_clk) begin
    if (!g_reset) begin
      for (int d = 0; d < 2; d++) cmp_port(d);
    end
  end

  // driver: called just after a posedge with the DUT in IDLE; returns just after the
  // posedge that ends the gnt cycle, leaving req high when hold is set
  task automatic run_txn(input int d, input logic [63:0] a, input logic w, input logic [7:0] s,
                         input logic [63:0] wd, input bit hold, input bit scramble,
                         output logic e_got, output logic [63:0] r_got,
                         output int acc, output int gcyc);
    exp_t e;
    req[d] = 1'b1; addr[d] = a; wen[d] = w; strb[d] = s; wdata[d] = wd;
    model_txn(d, a, w, s, wd, e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    acc = cyc + 1; gcyc = -1; e_got = 1'b0; r_got = '0;
    @(posedge g_clk); #1;
    if (scramble) begin
      addr[d] = {$urandom, $urandom}; wen[d] = ~w; strb[d] = ~s; wdata[d] = ~wd;
    end
    for (int k = 0; k < lat_of(d) + MAX_STALL + 2; k++) begin
      @(negedge g_clk);
      if (gnt[d]) begin
        e_got = err[d]; r_got = rdata[d]; gcyc = cyc;
        break;
      end
    end
    @(posedge g_clk); #1;
    if (!hold) req[d] = 1'b0;
  endtask

  task automatic rand_txn(input int d);
    logic [63:0] a;
    logic        e_got;
    logic [63:0] r_got;
    int          acc, gcyc, r;
    bit          hold;
    r = $urandom_range(0, 11);
    if (r < 9)       a = BASE + 64'($urandom_range(0, NW - 1)) * 8 + 64'($urandom_range(0, 7));
    else if (r == 9) a = BASE - 64'($urandom_range(1, 4)) * 8 + 64'($urandom_range(0, 7));
    else if (r == 10) a = BASE + SIZE + 64'($urandom_range(0, 3)) * 8 + 64'($urandom_range(0, 7));
    else             a = {$urandom, $urandom};
    hold = bit'($urandom_range(0, 1));
    run_txn(d, a, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
            {$urandom, $urandom}, hold, $urandom_range(0, 3) == 0,
            e_got, r_got, acc, gcyc);
    if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge g_clk); #1; end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_dut%0d_state", tag, d), 64'(dbg[d]), 64'd0);
      chk($sformatf("%s_dut%0d_gnt", tag, d), 64'(gnt[d]), 64'd0);
      chk($sformatf("%s_dut%0d_err", tag, d), 64'(err[d]), 64'd0);
      chk($sformatf("%s_dut%0d_rdata", tag, d), rdata[d], 64'd0);
    end
  endtask

  initial begin
    logic        e_got;
    logic [63:0] r_got;
    int          acc, gcyc, t0;

    repeat (3) @(posedge g_clk);
    #1 g_reset = 1'b0;
    @(negedge g_clk);
    chk_reset_state("reset");
    @(posedge g_clk); #1;

    // fill both arrays so every later read has a known expected value
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < NW; w++)
        run_txn(d, BASE + 64'(w) * 8, 1'b1, 8'hFF, {$urandom, $urandom}, 1'b0, 1'b0,
                e_got, r_got, acc, gcyc);

    // single-cycle read of word 0
    run_txn(0, BASE, 1'b1, 8'hFF, 64'h1122334455667788, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    run_txn(0, BASE, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    chk("t1_rdata", r_got, 64'h1122334455667788);
    chk("t1_err", 64'(e_got), 64'd0);
`ifndef DMEM_RESPONDER_STALL_EN
    chk("t1_latency", 64'(gcyc - acc + 1), 64'd1);
`endif

    // partial-strobe write, then strb=0 write that must leave the word alone
    run_txn(0, BASE + 8, 1'b1, 8'hFF, 64'h0, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    run_txn(0, BASE + 8, 1'b1, 8'h0F, 64'hFFFFFFFF_AABBCCDD, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    run_txn(0, BASE + 8, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    chk("t2_rdata", r_got, 64'h00000000_AABBCCDD);
    run_txn(0, BASE + 8, 1'b1, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    chk("t2_strb0_err", 64'(e_got), 64'd0);
    run_txn(0, BASE + 12, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    chk("t2_strb0_rdata", r_got, 64'h00000000_AABBCCDD);

    // out-of-range on both sides; the write just past the end must not alias word 0
    run_txn(0, BASE - 8, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    chk("t3_low_err", 64'(e_got), 64'd1);
    chk("t3_low_rdata", r_got, 64'd0);
    run_txn(0, BASE + SIZE, 1'b1, 8'hFF, 64'h5A5A5A5A_5A5A5A5A, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    chk("t3_high_err", 64'(e_got), 64'd1);
    chk("t3_high_rdata", r_got, 64'd0);
    run_txn(0, BASE, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    chk("t3_word0_kept", r_got, 64'h1122334455667788);

    // LATENCY=4 with req held across three reads
    run_txn(1, BASE, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, e_got, r_got, t0, gcyc);
`ifndef DMEM_RESPONDER_STALL_EN
    chk("t4_gnt1", 64'(gcyc - t0 + 1), 64'd4);
`endif
    run_txn(1, BASE + 8, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, e_got, r_got, acc, gcyc);
`ifndef DMEM_RESPONDER_STALL_EN
    chk("t4_gnt2", 64'(gcyc - t0 + 1), 64'd9);
`endif
    run_txn(1, BASE + 16, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
`ifndef DMEM_RESPONDER_STALL_EN
    chk("t4_gnt3", 64'(gcyc - t0 + 1), 64'd14);
`endif

    // reset while a write waits: no gnt, no commit
    run_txn(1, BASE + 40, 1'b1, 8'hFF, 64'hDEADBEEF_01234567, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    req[1] = 1'b1; addr[1] = BASE + 40; wen[1] = 1'b1; strb[1] = 8'hFF; wdata[1] = '1;
    @(posedge g_clk); #1;
    chk("t5_in_wait", 64'(dbg[1]), 64'd1);
    req[1] = 1'b0; g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    chk_reset_state("t5_reset");
    repeat (6) @(posedge g_clk);
    #1;
    run_txn(1, BASE + 40, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, e_got, r_got, acc, gcyc);
    chk("t5_rdata_kept", r_got, 64'hDEADBEEF_01234567);

    // randomized traffic against the scoreboard
    for (int n = 0; n < 700; n++) rand_txn(0);
    req[0] = 1'b0;
    for (int n = 0; n < 300; n++) rand_txn(1);
    req[1] = 1'b0;

    repeat (10) @(posedge g_clk);
    @(negedge g_clk);
    chk("drain_q0", 64'(exp_q0.size()), 64'd0);
    chk("drain_q1", 64'(exp_q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
